// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mdu_pkg
//  Purpose  : Shared funct codes, FSM states and op kinds for the MDU.
//  Revision : 1.0
// ============================================================================
package mdu_pkg;

    localparam logic [5:0] c_FUNCT_MFHI  = 6'b010000;
    localparam logic [5:0] c_FUNCT_MTHI  = 6'b010001;
    localparam logic [5:0] c_FUNCT_MFLO  = 6'b010010;
    localparam logic [5:0] c_FUNCT_MTLO  = 6'b010011;
    localparam logic [5:0] c_FUNCT_MULT  = 6'b011000;
    localparam logic [5:0] c_FUNCT_MULTU = 6'b011001;
    localparam logic [5:0] c_FUNCT_DIV   = 6'b011010;
    localparam logic [5:0] c_FUNCT_DIVU  = 6'b011011;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } mdu_state_t;

    typedef enum logic {
        OP_MUL = 1'b0,
        OP_DIV = 1'b1
    } mdu_op_t;

    // The eight MDU functs occupy 0100xx (HI/LO moves) and 0110xx (mult/div).
    function automatic logic f_is_mdu(input logic [5:0] funct);
        return (funct[5:2] == 4'b0100) || (funct[5:2] == 4'b0110);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_controller_if.sv
`default_nettype none
// ============================================================================
//  Module   : mdu_controller_if
//  Purpose  : EX-stage <-> MDU handshake bundle (master = pipeline, slave = MDU).
//  Revision : 1.0
// ============================================================================
interface mdu_controller_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  op_valid;
    logic [5:0]            funct;
    logic [DATA_WIDTH-1:0] rs_val;
    logic [DATA_WIDTH-1:0] rt_val;
    logic                  kill;
    logic                  stall;
    logic                  busy;
    logic [DATA_WIDTH-1:0] mf_result;
    logic [DATA_WIDTH-1:0] hi_out;
    logic [DATA_WIDTH-1:0] lo_out;

    modport master (
        output op_valid, funct, rs_val, rt_val, kill,
        input  stall, busy, mf_result, hi_out, lo_out
    );

    modport slave (
        input  op_valid, funct, rs_val, rt_val, kill,
        output stall, busy, mf_result, hi_out, lo_out
    );
endinterface
`default_nettype wire

// File: rtl/mdu_iter_core.sv
`default_nettype none
// ============================================================================
//  Module   : mdu_iter_core
//  Purpose  : One-bit-per-cycle shift-add / restoring-divide datapath plus the
//             final sign fix-up of HI/LO.
//  Revision : 1.0
// ============================================================================
module mdu_iter_core
    import mdu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 5
) (
    input  wire logic                  clk,
    input  wire logic                  i_load,
    input  wire logic                  i_load_div,
    input  wire logic                  i_step,
    input  wire mdu_op_t               i_op,
    input  wire logic [DATA_WIDTH-1:0] i_a_mag,
    input  wire logic [DATA_WIDTH-1:0] i_b_mag,
    input  wire logic                  i_sign_a,
    input  wire logic                  i_sign_b,
    input  wire logic                  i_div0,
    input  wire logic [CNT_WIDTH-1:0]  i_shift,
    output logic                       o_mplr_zero,
    output logic [DATA_WIDTH-1:0]      o_hi,
    output logic [DATA_WIDTH-1:0]      o_lo
);

    // Multiply: r_acc accumulates from the top and shifts right; r_b holds the
    // multiplicand.  Divide: r_acc = {remainder, dividend/quotient}; r_b = divisor.
    logic [2*DATA_WIDTH-1:0] r_acc;
    logic [DATA_WIDTH-1:0]   r_b;
    logic [DATA_WIDTH-1:0]   r_mplr;

    logic [DATA_WIDTH:0]     w_madd;
    logic [2*DATA_WIDTH-1:0] w_mul_next;
    logic [DATA_WIDTH:0]     w_rsh;
    logic [DATA_WIDTH:0]     w_trial;
    logic                    w_qbit;
    logic [2*DATA_WIDTH-1:0] w_div_next;
    logic [2*DATA_WIDTH-1:0] w_prod;
    logic [2*DATA_WIDTH-1:0] w_prod_fix;
    logic [DATA_WIDTH-1:0]   w_quo_fix;
    logic [DATA_WIDTH-1:0]   w_rem_fix;

    assign w_madd     = {1'b0, r_acc[2*DATA_WIDTH-1:DATA_WIDTH]}
                      + (r_mplr[0] ? {1'b0, r_b} : {(DATA_WIDTH+1){1'b0}});
    assign w_mul_next = {w_madd, r_acc[DATA_WIDTH-1:1]};

    assign w_rsh      = {r_acc[2*DATA_WIDTH-1:DATA_WIDTH], r_acc[DATA_WIDTH-1]};
    assign w_trial    = w_rsh - {1'b0, r_b};
    assign w_qbit     = ~w_trial[DATA_WIDTH];
    assign w_div_next = {(w_qbit ? w_trial[DATA_WIDTH-1:0] : w_rsh[DATA_WIDTH-1:0]),
                         r_acc[DATA_WIDTH-2:0], w_qbit};

    assign o_mplr_zero = (r_mplr[DATA_WIDTH-1:1] == '0);

    always_ff @(posedge clk) begin
        if (i_load) begin
            r_acc  <= i_load_div ? {{DATA_WIDTH{1'b0}}, i_a_mag} : '0;
            r_b    <= i_load_div ? i_b_mag : i_a_mag;
            r_mplr <= i_b_mag;
        end else if (i_step) begin
            r_acc  <= (i_op == OP_DIV) ? w_div_next : w_mul_next;
            r_mplr <= r_mplr >> 1;
        end
    end

    // A zero divisor leaves quotient all-ones and the remainder equal to |dividend|;
    // only the remainder sign fix applies, which restores the raw dividend.
    assign w_prod     = r_acc >> i_shift;
    assign w_prod_fix = (i_sign_a ^ i_sign_b) ? -w_prod : w_prod;
    assign w_quo_fix  = ((i_sign_a ^ i_sign_b) & ~i_div0) ? -r_acc[DATA_WIDTH-1:0]
                                                         :  r_acc[DATA_WIDTH-1:0];
    assign w_rem_fix  = i_sign_a ? -r_acc[2*DATA_WIDTH-1:DATA_WIDTH]
                                 :  r_acc[2*DATA_WIDTH-1:DATA_WIDTH];

    always_comb begin
        o_hi = w_rem_fix;
        o_lo = w_quo_fix;
        if (i_op == OP_MUL) begin
            o_hi = w_prod_fix[2*DATA_WIDTH-1:DATA_WIDTH];
            o_lo = w_prod_fix[DATA_WIDTH-1:0];
        end
    end

endmodule
`default_nettype wire

// File: rtl/mdu_controller.sv
`default_nettype none
// ============================================================================
//  Module   : mdu_controller
//  Purpose  : MDU sequencer: FSM, iteration counter, stall generation, HI/LO.
//             Define MDU_EARLY_TERM_EN for early-terminating multiplies.
//  Revision : 1.0
// ============================================================================
module mdu_controller
    import mdu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 5
) (
    input  wire logic        clk,
    input  wire logic        rst,
    mdu_controller_if.slave  bus
);

    mdu_state_t              r_state;
    mdu_op_t                 r_op;
    logic [CNT_WIDTH-1:0]    r_cnt;
    logic [DATA_WIDTH-1:0]   r_hi;
    logic [DATA_WIDTH-1:0]   r_lo;
    logic                    r_busy;
    logic                    r_sign_a;
    logic                    r_sign_b;
    logic                    r_div0;

    logic                    w_is_mdu;
    logic                    w_accept;
    logic                    w_is_muldiv;
    logic                    w_signed;
    logic                    w_neg_a;
    logic                    w_neg_b;
    logic [DATA_WIDTH-1:0]   w_a_mag;
    logic [DATA_WIDTH-1:0]   w_b_mag;
    logic                    w_load;
    logic                    w_step;
    logic                    w_last;
    logic [CNT_WIDTH-1:0]    w_cnt_exit;
    logic [CNT_WIDTH-1:0]    w_shift;
    logic                    w_mplr_zero;
    logic [DATA_WIDTH-1:0]   w_core_hi;
    logic [DATA_WIDTH-1:0]   w_core_lo;
    logic [DATA_WIDTH-1:0]   w_mf_result;

    assign w_is_mdu    = f_is_mdu(bus.funct);
    assign w_accept    = bus.op_valid & w_is_mdu & ~r_busy & ~bus.kill & ~rst;
    assign w_is_muldiv = bus.funct[3];
    assign w_signed    = ~bus.funct[0];
    assign w_neg_a     = w_signed & bus.rs_val[DATA_WIDTH-1];
    assign w_neg_b     = w_signed & bus.rt_val[DATA_WIDTH-1];
    assign w_a_mag     = w_neg_a ? -bus.rs_val : bus.rs_val;
    assign w_b_mag     = w_neg_b ? -bus.rt_val : bus.rt_val;
    assign w_load      = w_accept & w_is_muldiv;
    assign w_step      = (r_state == S_CALC);

`ifdef MDU_EARLY_TERM_EN
    // On early exit the counter keeps the number of skipped steps, which FIX
    // applies as a single right shift of the product.
    assign w_last     = (r_cnt == '0) | ((r_op == OP_MUL) & w_mplr_zero);
    assign w_cnt_exit = r_cnt;
    assign w_shift    = r_cnt;
`else
    logic w_unused_mplr;
    assign w_unused_mplr = w_mplr_zero;
    assign w_last        = (r_cnt == '0);
    assign w_cnt_exit    = r_cnt - CNT_WIDTH'(1);
    assign w_shift       = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_op     <= OP_MUL;
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_busy   <= 1'b0;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_div0   <= 1'b0;
        end else if (bus.kill) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (w_is_muldiv) begin
                            r_op     <= bus.funct[1] ? OP_DIV : OP_MUL;
                            r_sign_a <= w_neg_a;
                            r_sign_b <= w_neg_b;
                            r_div0   <= (bus.rt_val == '0);
                            r_cnt    <= CNT_WIDTH'(DATA_WIDTH - 1);
                            r_state  <= S_CALC;
                            r_busy   <= 1'b1;
                        end else if (bus.funct == c_FUNCT_MTHI) begin
                            r_hi <= bus.rs_val;
                        end else if (bus.funct == c_FUNCT_MTLO) begin
                            r_lo <= bus.rs_val;
                        end
                    end
                end
                S_CALC: begin
                    if (w_last) begin
                        r_state <= S_FIX;
                        r_cnt   <= w_cnt_exit;
                    end else begin
                        r_cnt <= r_cnt - CNT_WIDTH'(1);
                    end
                end
                S_FIX: begin
                    r_hi    <= w_core_hi;
                    r_lo    <= w_core_lo;
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        w_mf_result = '0;
        if (bus.op_valid & ~r_busy & ~bus.kill & ~rst) begin
            if (bus.funct == c_FUNCT_MFHI) begin
                w_mf_result = r_hi;
            end else if (bus.funct == c_FUNCT_MFLO) begin
                w_mf_result = r_lo;
            end
        end
    end

    assign bus.stall     = bus.op_valid & r_busy & w_is_mdu & ~rst;
    assign bus.busy      = r_busy;
    assign bus.mf_result = w_mf_result;
    assign bus.hi_out    = r_hi;
    assign bus.lo_out    = r_lo;

    mdu_iter_core #(
        .DATA_WIDTH (DATA_WIDTH),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_core (
        .clk         (clk),
        .i_load      (w_load),
        .i_load_div  (bus.funct[1]),
        .i_step      (w_step),
        .i_op        (r_op),
        .i_a_mag     (w_a_mag),
        .i_b_mag     (w_b_mag),
        .i_sign_a    (r_sign_a),
        .i_sign_b    (r_sign_b),
        .i_div0      (r_div0),
        .i_shift     (w_shift),
        .o_mplr_zero (w_mplr_zero),
        .o_hi        (w_core_hi),
        .o_lo        (w_core_lo)
    );

endmodule
`default_nettype wire

// File: tb/tb_mdu_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mdu_controller
//  Purpose  : Self-checking bench: vector table, multi-cycle corner sequences
//             and randomized ops against an arithmetic HI/LO model.
//  Revision : 1.0
// ============================================================================
module tb_mdu_controller;

    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_ADD   = 6'b100000;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    mdu_controller_if #(.DATA_WIDTH(32)) bus ();

    mdu_controller #(.DATA_WIDTH(32), .CNT_WIDTH(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference arithmetic straight from the instruction definitions.
    task automatic model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] p;
        logic [63:0]        u;
        case (f)
            F_MTHI: m_hi = a;
            F_MTLO: m_lo = a;
            F_MULT: begin
                p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
                {m_hi, m_lo} = p;
            end
            F_MULTU: begin
                u = {32'd0, a} * {32'd0, b};
                {m_hi, m_lo} = u;
            end
            F_DIV, F_DIVU: begin
                if (b == 32'd0) begin
                    m_lo = 32'hFFFF_FFFF;
                    m_hi = a;
                end else if (f == F_DIV && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    m_lo = 32'h8000_0000;
                    m_hi = 32'd0;
                end else if (f == F_DIV) begin
                    m_lo = $signed(a) / $signed(b);
                    m_hi = $signed(a) % $signed(b);
                end else begin
                    m_lo = a / b;
                    m_hi = a % b;
                end
            end
            default: ;
        endcase
    endtask

    function automatic int exp_busy(input logic [5:0] f, input logic [31:0] b);
        if (f == F_MTHI || f == F_MTLO) return 0;
`ifdef MDU_EARLY_TERM_EN
        if (f == F_MULT || f == F_MULTU) begin
            logic [31:0] mag;
            int n;
            mag = (f == F_MULT && b[31]) ? -b : b;
            n = 1;
            for (int i = 0; i < 32; i++) if (mag[i]) n = i + 1;
            return n + 1;
        end
`endif
        return 33;
    endfunction

    task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        bus.op_valid = 1'b1;
        bus.funct    = f;
        bus.rs_val   = a;
        bus.rt_val   = b;
        tick();
        bus.op_valid = 1'b0;
        bus.funct    = F_ADD;
    endtask

    task automatic run_check(input string name, input logic [5:0] f,
                             input logic [31:0] a, input logic [31:0] b);
        int cyc;
        model(f, a, b);
        issue(f, a, b);
        cyc = 0;
        while (bus.busy && cyc < 200) begin
            cyc++;
            tick();
        end
        chk({name, "_busy"}, 64'(cyc), 64'(exp_busy(f, b)));
        chk({name, "_hi"}, {32'd0, bus.hi_out}, {32'd0, m_hi});
        chk({name, "_lo"}, {32'd0, bus.lo_out}, {32'd0, m_lo});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        logic [5:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [5:0]  fsel [6];
        logic [31:0] spec [5];

        total = 0;
        bad   = 0;
        m_hi  = '0;
        m_lo  = '0;
        bus.op_valid = 1'b0;
        bus.funct    = F_ADD;
        bus.rs_val   = '0;
        bus.rt_val   = '0;
        bus.kill     = 1'b0;

        vecs[0] = '{F_MULT,  32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
        vecs[1] = '{F_MULTU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[2] = '{F_DIV,   32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3] = '{F_DIVU,  32'h1234_5678,  32'd0,         32'h1234_5678, 32'hFFFF_FFFF};
        vecs[4] = '{F_DIV,   32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vecs[5] = '{F_DIV,   32'h8000_0005,  32'd0,         32'h8000_0005, 32'hFFFF_FFFF};
        vecs[6] = '{F_MULTU, 32'h0001_0000,  32'h0001_0000, 32'h0000_0001, 32'h0000_0000};
        vecs[7] = '{F_DIVU,  32'd100,        32'd7,         32'h0000_0002, 32'h0000_000E};
        vecs[8] = '{F_DIV,   32'd7,          32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};

        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", {63'd0, bus.busy}, 64'd0);
        chk("rst_hi", {32'd0, bus.hi_out}, 64'd0);
        chk("rst_lo", {32'd0, bus.lo_out}, 64'd0);
        chk("rst_stall", {63'd0, bus.stall}, 64'd0);

        // Table vectors: constants from hand arithmetic, also cross-checked with the model.
        for (int i = 0; i < 9; i++) begin
            run_check($sformatf("vec%0d", i), vecs[i].f, vecs[i].a, vecs[i].b);
            chk($sformatf("vec%0d_tbl_hi", i), {32'd0, bus.hi_out}, {32'd0, vecs[i].hi});
            chk($sformatf("vec%0d_tbl_lo", i), {32'd0, bus.lo_out}, {32'd0, vecs[i].lo});
        end

        // mthi in IDLE, then read both registers back.
        @(posedge clk); #1;
        bus.op_valid = 1'b1; bus.funct = F_MTHI; bus.rs_val = 32'hAAAA_0000;
        @(negedge clk);
        chk("mthi_stall", {63'd0, bus.stall}, 64'd0);
        tick();
        model(F_MTHI, 32'hAAAA_0000, 32'd0);
        bus.funct = F_MFLO;
        @(negedge clk);
        chk("mflo_val", {32'd0, bus.mf_result}, {32'd0, m_lo});
        chk("mthi_hi", {32'd0, bus.hi_out}, 64'h0000_0000_AAAA_0000);
        bus.funct = F_MFHI;
        @(negedge clk);
        chk("mfhi_val", {32'd0, bus.mf_result}, 64'h0000_0000_AAAA_0000);
        bus.funct = F_ADD;
        @(negedge clk);
        chk("mf_nonmf", {32'd0, bus.mf_result}, 64'd0);
        @(posedge clk); #1;

        // kill in IDLE suppresses an mtlo.
        bus.op_valid = 1'b1; bus.funct = F_MTLO; bus.rs_val = 32'h0000_0055; bus.kill = 1'b1;
        tick();
        bus.op_valid = 1'b0; bus.funct = F_ADD; bus.kill = 1'b0;
        @(negedge clk);
        chk("kill_idle_lo", {32'd0, bus.lo_out}, {32'd0, m_lo});

        // Dependent mfhi issued 5 cycles into a multiply stalls until busy falls.
        @(posedge clk); #1;
        model(F_MULTU, 32'h0001_2345, 32'h8000_0003);
        issue(F_MULTU, 32'h0001_2345, 32'h8000_0003);
        bus.op_valid = 1'b1; bus.funct = F_ADD;
        @(negedge clk);
        chk("indep_nostall", {63'd0, bus.stall}, 64'd0);
        bus.op_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        bus.op_valid = 1'b1; bus.funct = F_MFHI;
        n = 0;
        @(negedge clk);
        while (bus.stall && n < 100) begin
            n++;
            @(posedge clk);
            @(negedge clk);
        end
        chk("mfhi_stall_cycles", 64'(n), 64'(exp_busy(F_MULTU, 32'h8000_0003) - 4));
        chk("mfhi_after_busy", {63'd0, bus.busy}, 64'd0);
        chk("mfhi_new_hi", {32'd0, bus.mf_result}, {32'd0, m_hi});
        tick();
        bus.op_valid = 1'b0; bus.funct = F_ADD;

        // kill in busy cycle 10 of a divide.
        issue(F_DIV, 32'h0BAD_F00D, 32'd13);
        for (int i = 0; i < 9; i++) tick();
        bus.kill = 1'b1;
        tick();
        bus.kill = 1'b0;
        chk("kill10_busy", {63'd0, bus.busy}, 64'd0);
        chk("kill10_hi", {32'd0, bus.hi_out}, {32'd0, m_hi});
        for (int i = 0; i < 35; i++) tick();
        chk("kill10_lo_late", {32'd0, bus.lo_out}, {32'd0, m_lo});

        // kill during FIX (33rd busy cycle of a divide) blocks the write.
        issue(F_DIVU, 32'h7777_0000, 32'd3);
        for (int i = 0; i < 32; i++) tick();
        chk("killfix_still_busy", {63'd0, bus.busy}, 64'd1);
        bus.kill = 1'b1;
        tick();
        bus.kill = 1'b0;
        chk("killfix_busy", {63'd0, bus.busy}, 64'd0);
        chk("killfix_hi", {32'd0, bus.hi_out}, {32'd0, m_hi});
        chk("killfix_lo", {32'd0, bus.lo_out}, {32'd0, m_lo});

        // Randomized ops with a bias toward boundary operands.
        fsel = '{F_MULT, F_MULTU, F_DIV, F_DIVU, F_MTHI, F_MTLO};
        spec = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
        for (int i = 0; i < 24; i++) begin
            f = fsel[$urandom_range(0, 5)];
            a = ($urandom_range(0, 3) == 0) ? spec[$urandom_range(0, 4)] : $urandom;
            b = ($urandom_range(0, 3) == 0) ? spec[$urandom_range(0, 4)] : $urandom;
            run_check($sformatf("rnd%0d", i), f, a, b);
        end

        // Reset in the middle of a multiply.
        issue(F_MULT, 32'h1234_5678, 32'h8765_4321);
        for (int i = 0; i < 4; i++) tick();
        bus.op_valid = 1'b1; bus.funct = F_MFHI; rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_stall", {63'd0, bus.stall}, 64'd0);
        chk("rst_mid_mf", {32'd0, bus.mf_result}, 64'd0);
        tick();
        rst = 1'b0; bus.op_valid = 1'b0; bus.funct = F_ADD;
        chk("rst_mid_busy", {63'd0, bus.busy}, 64'd0);
        chk("rst_mid_hi", {32'd0, bus.hi_out}, 64'd0);
        chk("rst_mid_lo", {32'd0, bus.lo_out}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mdu_controller.md
Name: mdu_controller

Overview:
- Sequencer for the iterative multiply/divide unit (MDU) beside the main ALU in the EX stage.
- Accepts R-type mult/multu/div/divu, moves/reads HI/LO via mthi/mtlo/mfhi/mflo, and owns the HI/LO registers.
- Issues the pipeline stall when a dependent HI/LO or MDU instruction meets an in-flight operation.
- Independent instructions keep flowing while the MDU iterates.

Parameters:
- DATA_WIDTH, 32, operand width and HI/LO width.
- CNT_WIDTH, 5, iteration counter width; must satisfy 2^CNT_WIDTH >= DATA_WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- op_valid  input  1  EX holds an R-type (alu_op=010) instruction this cycle.
- funct  input  6  instruction funct field.
- rs_val  input  DATA_WIDTH  forwarded rs operand (multiplicand/dividend, mthi/mtlo source).
- rt_val  input  DATA_WIDTH  forwarded rt operand (multiplier/divisor).
- kill  input  1  exception flush; abort any in-flight operation.
- stall  output  1  combinational; hold IF/ID/EX this cycle.
- busy  output  1  registered; MDU not in IDLE.
- mf_result  output  DATA_WIDTH  HI (mfhi) or LO (mflo) value for EX writeback; 0 otherwise.
- hi_out  output  DATA_WIDTH  current HI register.
- lo_out  output  DATA_WIDTH  current LO register.

Behaviour:
- Reset:
  - Synchronous: at a rising clk edge with rst=1, state=IDLE, counter=0, HI=LO=0, busy=0.
  - stall=0 and mf_result=0 while rst is high.
  - Reset mid-operation discards the operation.
- Decoded funct values:
  - mult 011000, multu 011001, div 011010, divu 011011.
  - mfhi 010000, mthi 010001, mflo 010010, mtlo 010011.
  - Any other funct is ignored by this block.
- stall = op_valid & busy & (funct is any of the eight MDU functs). No stall when busy=0.
- A non-stalled op_valid MDU instruction is accepted the same cycle.
- FSM IDLE -> CALC -> FIX -> IDLE:
  - IDLE:
    - Accepted mult/div latches operand magnitudes: two's-complement abs for signed ops, raw for unsigned.
    - It also latches the sign flags and op kind, loads counter=DATA_WIDTH-1, and moves to CALC.
    - mthi/mtlo write HI/LO at the accept edge.
    - mfhi/mflo drive mf_result combinationally from the current HI/LO.
  - CALC, multiply: one shift-add step per cycle on a 2*DATA_WIDTH accumulator.
  - CALC, divide: one restoring shift-subtract step per cycle.
  - CALC exit: decrement the counter and go to FIX after the step taken with counter=0, i.e. DATA_WIDTH cycles in CALC.
  - FIX, mult: negate the product if signA^signB.
  - FIX, div: negate the quotient if signA^signB; the remainder takes the dividend's sign.
  - FIX writeback: HI/LO are written at the FIX edge (mult: HI=upper, LO=lower; div: LO=quotient, HI=remainder), then return to IDLE.
- Latency: issue at edge N gives busy=1 from N+1 through N+DATA_WIDTH+1; new HI/LO are visible at N+DATA_WIDTH+2 (34 cycles at default).
- Divide by zero (divisor=0):
  - Result is LO=all ones, HI=dividend.
  - Same for signed and unsigned; no sign fix-up, no exception.
  - Full iteration latency is kept.
- Signed overflow: div of most-negative by -1 gives LO=most-negative, HI=0.
- kill:
  - Highest priority after rst; from CALC/FIX, next state is IDLE with HI/LO unchanged.
  - A kill in FIX blocks the write.
  - In IDLE, kill suppresses acceptance in that cycle, including mthi/mtlo writes.
- Simultaneous FIX and a new stalled instruction: stall is still asserted that cycle because busy=1; the instruction is accepted next cycle with updated HI/LO.

Optional Feature:
- Macro: MDU_EARLY_TERM_EN.
- Defined:
  - Multiply leaves CALC early once the remaining unshifted multiplier bits are all zero.
  - The accumulator is aligned with one shift by the remaining count in FIX.
  - Latency is 2 to DATA_WIDTH+1 busy cycles. Example: multiplier 0 or 1 gives 2 busy cycles.
  - Divide latency is unchanged.
- Not defined: fixed latency as above. Results are identical in both builds.

Decomposition:
- Shared package mdu_pkg holds:
  - Funct localparams for the eight MDU ops.
  - The FSM state encoding (IDLE, CALC, FIX).
  - The op-kind encoding (MUL, DIV).
- Sub-module mdu_iter_core contains only the per-cycle shift-add/shift-subtract datapath and the final sign fix-up.
- mdu_controller keeps the FSM, counter, stall logic and HI/LO.

Test Plan:
- mult rs=7, rt=0xFFFFFFFD (-3) -> busy for 33 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- multu 0xFFFFFFFF x 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- div -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu 0x12345678/0 -> LO=0xFFFFFFFF, HI=0x12345678.
- mfhi presented 5 cycles after mult issue:
  - stall=1 until busy falls.
  - mfhi is accepted at N+DATA_WIDTH+2 with mf_result equal to the new HI.
  - An independent non-MDU funct (e.g. add 100000) during busy -> stall=0.
- mthi 0xAAAA0000 in IDLE, then mflo/mfhi -> HI=0xAAAA0000, LO unchanged.
- kill in cycle 10 of a div, and separately in FIX -> busy=0 next cycle, HI/LO hold prior values.
- rst asserted mid-multiply -> HI=LO=0, busy=0 next cycle.
